uart_tx_top: RTL

Memory-mapped UART transmitter peripheral on the SoC data bus, alongside the factorial and GPIO peripherals. The address decoder drives its `we`, and its `rd` feeds a spare input of the read-data mux. Stores written bytes in a small FIFO and serialises them on `txd` as 8N1 frames at a programmable baud divisor. Also raises a level interrupt when transmission is complete.

---
 rtl/uart_tx_top_if.sv | 11 +
 rtl/uart_tx_top.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top_if.sv
// Register-bus port of uart_tx_top: 2-bit select, write strobe/data and
// combinational read data.
interface uart_tx_top_if;
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output a, we, wd, input rd);
    modport slave  (input a, we, wd, output rd);
endinterface

// File: rtl/uart_tx_top.sv
// Memory-mapped UART transmitter: DEPTH-entry byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_top #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_top_if.slave bus,
    output logic         txd,
    output logic         irq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_EN = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic PAR_EN = 1'b0;
`endif

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_div, r_bit_div, r_baud;
    logic          r_en, r_ovf;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic        w_empty, w_full, w_busy, w_push, w_pop, w_ovf_set, w_bit_end;
    logic        w_wr_data, w_wr_status, w_wr_div, w_wr_ctrl;
    logic [15:0] w_div_eff;
    logic        w_unused_wd;

    assign w_wr_data   = bus.we && (bus.a == 2'd0);
    assign w_wr_status = bus.we && (bus.a == 2'd1);
    assign w_wr_div    = bus.we && (bus.a == 2'd2);
    assign w_wr_ctrl   = bus.we && (bus.a == 2'd3);
    assign w_unused_wd = ^bus.wd[31:16];

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_busy    = (r_state != IDLE);
    assign w_div_eff = (r_div == '0) ? 16'd1 : r_div;
    assign w_bit_end = (r_baud == r_bit_div - 16'd1);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push    = w_wr_data && (!w_full || w_pop);
    assign w_ovf_set = w_wr_data && w_full && !w_pop;

    assign irq = r_en && w_empty && !w_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= DEFAULT_DIV;
            r_en  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_div)
                r_div <= bus.wd[15:0];
            if (w_wr_ctrl)
                r_en <= bus.wd[0];
            if (w_wr_status)
                r_ovf <= 1'b0;
            else if (w_ovf_set)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= bus.wd[7:0];
    end

    // Baud period is re-sampled at every bit start, so DIV writes apply from the next bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_baud    <= '0;
            r_bit_div <= 16'd1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_shift   <= r_mem[r_rptr];
                r_bitcnt  <= '0;
                r_baud    <= '0;
                r_bit_div <= w_div_eff;
`ifdef UART_TX_PARITY_EN
                r_par     <= ^r_mem[r_rptr];
`endif
            end else if (w_busy) begin
                if (w_bit_end) begin
                    r_baud    <= '0;
                    r_bit_div <= w_div_eff;
                    if (r_state == DATA) begin
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        txd         = 1'b1;
        case (r_state)
            IDLE: begin
                if (r_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (w_bit_end)
                    w_state_nxt = DATA;
            end
            DATA: begin
                txd = r_shift[0];
                if (w_bit_end && (r_bitcnt == 3'd7))
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd = r_par;
                if (w_bit_end)
                    w_state_nxt = STOP;
            end
`endif
            STOP: begin
                if (w_bit_end)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.rd = '0;
        case (bus.a)
            2'd1:    bus.rd = {27'b0, PAR_EN, r_ovf, w_busy, w_full, w_empty};
            2'd2:    bus.rd = {16'b0, r_div};
            2'd3:    bus.rd = {31'b0, r_en};
            default: bus.rd = '0;
        endcase
    end
endmodule
